// File: rtl/ram_ctrl_pkg.sv
// Shared types and widths for the 32x3 RAM pair control path.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 3;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    WRITE    = 2'd2,
    REL_DB   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/ram_port_ctrl_tick_gen.sv
// Free-running step timer; a step that falls due while hold is high is issued one cycle late,
// without disturbing the counter, so the long-run period is unchanged.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_pending;
  logic             w_due;

  assign w_due = (r_tick_cnt == CNT_W'(TICK_CYCLES - 1));
  assign tick  = (w_due | r_pending) & ~hold;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_tick_cnt <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_due) r_tick_cnt <= '0;
      else       r_tick_cnt <= r_tick_cnt + 1'b1;
      r_pending <= (w_due | r_pending) & hold;
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// Debounced write strobe plus 1 s read-address scan for the RAM pair.
// Optional WR_AUTOINC_EN: write address comes from an internal pointer instead of wr_addr_in.
module ram_port_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYCLES     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic              wr_key_n,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rd_tick,
  output logic              busy
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  logic        r_key_meta;
  logic        r_key_s;
  ctrl_state_t r_state;
  ctrl_state_t w_state_d;
  logic [DB_W-1:0] r_db_cnt;
  logic [DB_W-1:0] w_db_cnt_d;
  logic        w_load;
  logic        w_tick;
  addr_t       w_wr_addr;
  addr_t       r_wraddress;
  data_t       r_data;
  addr_t       r_rdaddress;
  logic        r_rd_tick;

  // Synchronizer idles high so a reset never looks like a press.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_key_meta <= 1'b1;
      r_key_s    <= 1'b1;
    end else begin
      r_key_meta <= wr_key_n;
      r_key_s    <= r_key_meta;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_db_cnt_d = r_db_cnt;
    case (r_state)
      IDLE: begin
        if (!r_key_s) begin
          w_state_d  = PRESS_DB;
          w_db_cnt_d = DB_W'(1);
        end
      end
      PRESS_DB: begin
        if (r_key_s) begin
          w_state_d  = IDLE;
          w_db_cnt_d = '0;
        end else if (r_db_cnt == DB_MAX) begin
          w_state_d  = WRITE;
          w_db_cnt_d = '0;
        end else begin
          w_db_cnt_d = r_db_cnt + 1'b1;
        end
      end
      WRITE: begin
        w_state_d  = REL_DB;
        w_db_cnt_d = '0;
      end
      REL_DB: begin
        if (!r_key_s) begin
          w_db_cnt_d = '0;
        end else if (r_db_cnt == DB_MAX) begin
          w_state_d  = IDLE;
          w_db_cnt_d = '0;
        end else begin
          w_db_cnt_d = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d  = IDLE;
        w_db_cnt_d = '0;
      end
    endcase
  end

  // WRITE is only ever entered from PRESS_DB, so this fires once per accepted press.
  assign w_load = (w_state_d == WRITE);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_d;
      r_db_cnt <= w_db_cnt_d;
    end
  end

`ifdef WR_AUTOINC_EN
  addr_t r_wr_ptr;

  always_ff @(posedge CLOCK_50) begin
    if (Reset)       r_wr_ptr <= '0;
    else if (w_load) r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  assign w_wr_addr = r_wr_ptr;
`else
  assign w_wr_addr = wr_addr_in;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_wraddress <= '0;
      r_data      <= '0;
    end else if (w_load) begin
      r_wraddress <= w_wr_addr;
      r_data      <= wr_data_in;
    end
  end

  // Holding on the WRITE entry keeps rdaddress stable for the whole wren cycle.
  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .hold    (w_load),
    .tick    (w_tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_rdaddress <= '0;
      r_rd_tick   <= 1'b0;
    end else begin
      r_rd_tick <= w_tick;
      if (w_tick) r_rdaddress <= r_rdaddress + 1'b1;
    end
  end

  assign wren      = (r_state == WRITE);
  assign busy      = (r_state != IDLE);
  assign wraddress = r_wraddress;
  assign data      = r_data;
  assign rdaddress = r_rdaddress;
  assign rd_tick   = r_rd_tick;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with TICK_CYCLES=20, DEBOUNCE_CYCLES=4.
// Honours WR_AUTOINC_EN the same way the design does.
module tb_ram_port_ctrl;

  localparam int unsigned TICK = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic [4:0] wr_addr = '0;
  logic [2:0] wr_data = '0;
  logic       wren;
  logic [4:0] wraddress;
  logic [2:0] data;
  logic [4:0] rdaddress;
  logic       rd_tick;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int g_cyc = 0;

  ram_port_ctrl #(
    .TICK_CYCLES    (20),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50  (clk),
    .Reset     (rst),
    .wr_key_n  (key_n),
    .wr_addr_in(wr_addr),
    .wr_data_in(wr_data),
    .wren      (wren),
    .wraddress (wraddress),
    .data      (data),
    .rdaddress (rdaddress),
    .rd_tick   (rd_tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    g_cyc++;
  endtask

  function automatic logic [4:0] exp_rd(input int cyc);
    return 5'((cyc / TICK) % 32);
  endfunction

  // Full press: key low 10 cycles, then released for 12; captures what was written.
  task automatic do_press(input logic [4:0] a, input logic [2:0] d,
                          output logic [4:0] got_a, output logic [2:0] got_d,
                          output int pulses);
    pulses = 0;
    got_a  = 'x;
    got_d  = 'x;
    wr_addr = a;
    wr_data = d;
    key_n   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (wren) begin
        pulses++;
        got_a = wraddress;
        got_d = data;
      end
    end
    key_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (wren) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_vec += 6;
    if (wren !== 1'b0)      begin n_err++; $display("FAIL reset_wren got %b exp 0", wren); end
    if (wraddress !== 5'h0) begin n_err++; $display("FAIL reset_wraddr got %h exp 0", wraddress); end
    if (data !== 3'h0)      begin n_err++; $display("FAIL reset_data got %h exp 0", data); end
    if (rdaddress !== 5'h0) begin n_err++; $display("FAIL reset_rdaddr got %h exp 0", rdaddress); end
    if (rd_tick !== 1'b0)   begin n_err++; $display("FAIL reset_rdtick got %b exp 0", rd_tick); end
    if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0;
    g_cyc = 0;
  endtask

  // 33 read steps: covers the 31->0 wrap and one step beyond it.
  task automatic test_scan();
    for (int k = 0; k < 33 * TICK; k++) begin
      step();
      n_vec += 2;
      if (rd_tick !== ((g_cyc % TICK) == 0)) begin
        n_err++;
        $display("FAIL scan_rdtick cyc %0d got %b exp %b", g_cyc, rd_tick, (g_cyc % TICK) == 0);
      end
      if (rdaddress !== exp_rd(g_cyc)) begin
        n_err++;
        $display("FAIL scan_rdaddr cyc %0d got %h exp %h", g_cyc, rdaddress, exp_rd(g_cyc));
      end
    end
  endtask

  task automatic test_write();
    logic [4:0] exp_a;
`ifdef WR_AUTOINC_EN
    exp_a = 5'h00;
`else
    exp_a = 5'h0A;
`endif
    wr_addr = 5'h0A;
    wr_data = 3'b101;
    key_n   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_vec++;
      if (wren !== (k == 7)) begin
        n_err++;
        $display("FAIL write_wren k %0d got %b exp %b", k, wren, k == 7);
      end
      if (k == 7) begin
        n_vec += 2;
        if (wraddress !== exp_a) begin
          n_err++; $display("FAIL write_addr got %h exp %h", wraddress, exp_a);
        end
        if (data !== 3'b101) begin
          n_err++; $display("FAIL write_data got %h exp 5", data);
        end
      end
    end
    // Registers must hold once the switches move.
    key_n   = 1'b1;
    wr_addr = 5'h15;
    wr_data = 3'b010;
    for (int k = 0; k < 10; k++) begin
      step();
      n_vec++;
      if (wren !== 1'b0) begin n_err++; $display("FAIL release_wren k %0d got %b exp 0", k, wren); end
    end
    n_vec += 3;
    if (busy !== 1'b0)  begin n_err++; $display("FAIL release_busy got %b exp 0", busy); end
    if (wraddress !== exp_a) begin
      n_err++; $display("FAIL hold_addr got %h exp %h", wraddress, exp_a);
    end
    if (data !== 3'b101) begin n_err++; $display("FAIL hold_data got %h exp 5", data); end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    key_n = 1'b0;
    step();
    step();
    key_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (wren) pulses++;
      if (j == 2) begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL bounce_busy_mid got %b exp 1", busy); end
      end
    end
    n_vec += 2;
    if (pulses != 0)   begin n_err++; $display("FAIL bounce_wren got %0d pulses exp 0", pulses); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL bounce_idle got %b exp 0", busy); end

    // One-cycle release in the middle of a long hold.
    pulses = 0;
    key_n = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); if (wren) pulses++; end
    key_n = 1'b1;
    step();
    if (wren) pulses++;
    key_n = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); if (wren) pulses++; end
    key_n = 1'b1;
    for (int k = 0; k < 12; k++) begin step(); if (wren) pulses++; end
    n_vec += 2;
    if (pulses != 1)   begin n_err++; $display("FAIL glitch_wren got %0d pulses exp 1", pulses); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle got %b exp 0", busy); end
  endtask

  task automatic test_collision();
    int guard;
    guard = 0;
    while ((g_cyc % TICK) != 13 && guard < 2 * TICK) begin
      step();
      guard++;
    end
    n_vec++;
    if ((g_cyc % TICK) != 13) begin
      n_err++; $display("FAIL coll_align got %0d exp 13", g_cyc % TICK);
    end
    key_n = 1'b0;
    for (int k = 0; k < 6; k++) step();
    n_vec++;
    if (wren !== 1'b0) begin n_err++; $display("FAIL coll_pre_wren got %b exp 0", wren); end
    step();
    n_vec += 3;
    if (wren !== 1'b1)    begin n_err++; $display("FAIL coll_wren got %b exp 1", wren); end
    if (rd_tick !== 1'b0) begin n_err++; $display("FAIL coll_rdtick got %b exp 0", rd_tick); end
    if (rdaddress !== exp_rd(g_cyc - 1)) begin
      n_err++; $display("FAIL coll_rdaddr got %h exp %h", rdaddress, exp_rd(g_cyc - 1));
    end
    step();
    n_vec += 3;
    if (wren !== 1'b0)    begin n_err++; $display("FAIL defer_wren got %b exp 0", wren); end
    if (rd_tick !== 1'b1) begin n_err++; $display("FAIL defer_rdtick got %b exp 1", rd_tick); end
    if (rdaddress !== exp_rd(g_cyc)) begin
      n_err++; $display("FAIL defer_rdaddr got %h exp %h", rdaddress, exp_rd(g_cyc));
    end
    key_n = 1'b1;
    for (int k = 0; k < TICK - 1; k++) begin
      step();
      n_vec += 2;
      if (rd_tick !== ((g_cyc % TICK) == 0)) begin
        n_err++;
        $display("FAIL sched_rdtick cyc %0d got %b exp %b", g_cyc, rd_tick, (g_cyc % TICK) == 0);
      end
      if (rdaddress !== exp_rd(g_cyc)) begin
        n_err++;
        $display("FAIL sched_rdaddr cyc %0d got %h exp %h", g_cyc, rdaddress, exp_rd(g_cyc));
      end
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 aborts in PRESS_DB (4 cycles low), pass 1 in REL_DB (9 cycles low).
      key_n = 1'b0;
      for (int k = 0; k < ((pass == 0) ? 4 : 9); k++) step();
      n_vec += 2;
      if (busy !== 1'b1) begin n_err++; $display("FAIL abort%0d_busy got %b exp 1", pass, busy); end
      if (wren !== 1'b0) begin n_err++; $display("FAIL abort%0d_wren got %b exp 0", pass, wren); end
      rst   = 1'b1;
      key_n = 1'b1;
      for (int k = 0; k < 3; k++) step();
      n_vec += 5;
      if (wraddress !== 5'h0) begin
        n_err++; $display("FAIL abort%0d_wraddr got %h exp 0", pass, wraddress);
      end
      if (data !== 3'h0) begin n_err++; $display("FAIL abort%0d_data got %h exp 0", pass, data); end
      if (rdaddress !== 5'h0) begin
        n_err++; $display("FAIL abort%0d_rdaddr got %h exp 0", pass, rdaddress);
      end
      if (rd_tick !== 1'b0) begin n_err++; $display("FAIL abort%0d_rdtick got %b exp 0", pass, rd_tick); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL abort%0d_rbusy got %b exp 0", pass, busy); end
      rst = 1'b0;
      g_cyc = 0;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin step(); if (wren) pulses++; end
      n_vec++;
      if (pulses != 0) begin n_err++; $display("FAIL abort%0d_post got %0d pulses exp 0", pass, pulses); end
    end
  endtask

  task automatic test_addr_mode();
    logic [4:0] a_in [3];
    logic [2:0] d_in [3];
    logic [4:0] got_a;
    logic [2:0] got_d;
    logic [4:0] exp_a;
    int pulses;
    a_in[0] = 5'h1F; a_in[1] = 5'h07; a_in[2] = 5'h12;
    d_in[0] = 3'd1;  d_in[1] = 3'd6;  d_in[2] = 3'd3;
    for (int i = 0; i < 3; i++) begin
      do_press(a_in[i], d_in[i], got_a, got_d, pulses);
`ifdef WR_AUTOINC_EN
      exp_a = 5'(i);
`else
      exp_a = a_in[i];
`endif
      n_vec += 3;
      if (pulses != 1) begin n_err++; $display("FAIL mode%0d_wren got %0d pulses exp 1", i, pulses); end
      if (got_a !== exp_a) begin n_err++; $display("FAIL mode%0d_addr got %h exp %h", i, got_a, exp_a); end
      if (got_d !== d_in[i]) begin
        n_err++; $display("FAIL mode%0d_data got %h exp %h", i, got_d, d_in[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_write();
    test_bounce();
    test_collision();
    test_reset_abort();
    test_addr_mode();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
